// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use detection and a per-register scoreboard for
// variable-latency writers; stall_o freezes PC/IF-ID and bubbles EX.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int NFWD   = 2,
    parameter int SELW   = $clog2(NFWD + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NFWD-1:0]          fwd_we_i,
    input  logic [NFWD*REG_AW-1:0]   fwd_rd_i,
    input  logic [NSRC*REG_AW-1:0]   ex_rs_i,
    output logic [NSRC*SELW-1:0]     fwd_sel_o,
    input  logic [NSRC*REG_AW-1:0]   id_rs_i,
    input  logic [NSRC-1:0]          id_rs_use_i,
    input  logic                     id_we_i,
    input  logic [REG_AW-1:0]        id_rd_i,
    input  logic                     ex_memread_i,
    input  logic [REG_AW-1:0]        ex_rd_i,
    input  logic                     lu_issue_i,
    input  logic [REG_AW-1:0]        lu_rd_i,
    input  logic                     lu_done_i,
    input  logic [REG_AW-1:0]        lu_done_rd_i,
    output logic                     stall_o,
    output logic [(2**REG_AW)-1:0]   busy_o,
    output logic [31:0]              stall_cnt_o
);

    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic            stall;

    // Walk stages from farthest to nearest so the nearest match is written last.
    always_comb begin
        fwd_sel_o = '0;
        for (int j = 0; j < NSRC; j++) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_we_i[k]
                    && fwd_rd_i[k*REG_AW +: REG_AW] == ex_rs_i[j*REG_AW +: REG_AW]
                    && fwd_rd_i[k*REG_AW +: REG_AW] != '0) begin
                    fwd_sel_o[j*SELW +: SELW] = SELW'(k + 1);
                end
            end
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            if (id_rs_use_i[j]) begin
                if (ex_memread_i && ex_rd_i != '0
                    && id_rs_i[j*REG_AW +: REG_AW] == ex_rd_i) begin
                    stall = 1'b1;
                end
                if (busy_q[id_rs_i[j*REG_AW +: REG_AW]]) begin
                    stall = 1'b1;
                end
            end
        end
        if (id_we_i && busy_q[id_rd_i]) begin
            stall = 1'b1;
        end
    end

    // Clear before set so an issue and completion on one register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (lu_done_i) begin
            busy_d[lu_done_rd_i] = 1'b0;
        end
        if (lu_issue_i && lu_rd_i != '0) begin
            busy_d[lu_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_o     = stall;
    assign busy_o      = busy_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use, scoreboard,
// WAW, asynchronous reset, counter saturation and a 3-operand/3-stage build.
module tb_fwd_hazard_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_rd;
    logic [9:0]  ex_rs;
    logic [3:0]  fwd_sel;
    logic [9:0]  id_rs;
    logic [1:0]  id_use;
    logic        id_we;
    logic [4:0]  id_rd;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        lu_issue;
    logic [4:0]  lu_rd;
    logic        lu_done;
    logic [4:0]  lu_done_rd;
    logic        stall;
    logic [31:0] busy;
    logic [31:0] stall_cnt;

    logic [2:0]  fwd_we3;
    logic [14:0] fwd_rd3;
    logic [14:0] ex_rs3;
    logic [5:0]  fwd_sel3;
    logic        stall3;
    logic [31:0] busy3;
    logic [31:0] stall_cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fwd_hazard_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fwd_we_i     (fwd_we),
        .fwd_rd_i     (fwd_rd),
        .ex_rs_i      (ex_rs),
        .fwd_sel_o    (fwd_sel),
        .id_rs_i      (id_rs),
        .id_rs_use_i  (id_use),
        .id_we_i      (id_we),
        .id_rd_i      (id_rd),
        .ex_memread_i (ex_memread),
        .ex_rd_i      (ex_rd),
        .lu_issue_i   (lu_issue),
        .lu_rd_i      (lu_rd),
        .lu_done_i    (lu_done),
        .lu_done_rd_i (lu_done_rd),
        .stall_o      (stall),
        .busy_o       (busy),
        .stall_cnt_o  (stall_cnt)
    );

    fwd_hazard_unit #(.REG_AW(5), .NSRC(3), .NFWD(3)) dut3 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fwd_we_i     (fwd_we3),
        .fwd_rd_i     (fwd_rd3),
        .ex_rs_i      (ex_rs3),
        .fwd_sel_o    (fwd_sel3),
        .id_rs_i      (15'd0),
        .id_rs_use_i  (3'd0),
        .id_we_i      (1'b0),
        .id_rd_i      (5'd0),
        .ex_memread_i (1'b0),
        .ex_rd_i      (5'd0),
        .lu_issue_i   (1'b0),
        .lu_rd_i      (5'd0),
        .lu_done_i    (1'b0),
        .lu_done_rd_i (5'd0),
        .stall_o      (stall3),
        .busy_o       (busy3),
        .stall_cnt_o  (stall_cnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        fwd_we = '0; fwd_rd = '0; ex_rs = '0;
        id_rs = '0; id_use = '0; id_we = 1'b0; id_rd = '0;
        ex_memread = 1'b0; ex_rd = '0;
        lu_issue = 1'b0; lu_rd = '0; lu_done = 1'b0; lu_done_rd = '0;
        fwd_we3 = '0; fwd_rd3 = '0; ex_rs3 = '0;

        next_cycle();
        check("reset_busy", busy, 32'd0);
        check("reset_cnt", stall_cnt, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_sel", {28'd0, fwd_sel}, 32'd0);
        #2 rst_i = 1'b1;
        next_cycle();

        // Forwarding priority
        fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; ex_rs = {5'd5, 5'd5};
        #1 check("fwd_mem_over_wb", {28'd0, fwd_sel}, 32'b0101);
        fwd_rd = {5'd5, 5'd0};
        #1 check("fwd_wb_only", {28'd0, fwd_sel}, 32'b1010);
        fwd_rd = {5'd0, 5'd0}; ex_rs = {5'd0, 5'd0};
        #1 check("fwd_reg_zero", {28'd0, fwd_sel}, 32'b0000);
        fwd_we = 2'b01; fwd_rd = {5'd5, 5'd6}; ex_rs = {5'd6, 5'd5};
        #1 check("fwd_we_gated", {28'd0, fwd_sel}, 32'b0100);
        fwd_we = 2'b10; ex_rs = {5'd6, 5'd5};
        #1 check("fwd_wb_op0", {28'd0, fwd_sel}, 32'b0010);
        fwd_we = '0; fwd_rd = '0; ex_rs = '0;
        next_cycle();

        // Load-use
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_use = 2'b10;
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        id_use = 2'b01;
        #1 check("lu_unused", {31'd0, stall}, 32'd0);
        check("cnt_after_lu", stall_cnt, 32'd1);
        ex_rd = 5'd0; id_rs = '0; id_use = 2'b11;
        #1 check("lu_rd_zero", {31'd0, stall}, 32'd0);
        next_cycle();
        ex_memread = 1'b0; id_use = '0;
        check("cnt_hold", stall_cnt, 32'd1);

        // Scoreboard RAW
        lu_issue = 1'b1; lu_rd = 5'd9;
        #1 check("sb_issue_busy", busy, 32'd0);
        next_cycle();
        lu_issue = 1'b0; id_rs = {5'd0, 5'd9}; id_use = 2'b01;
        #1 check("sb_busy9", busy, 32'h0000_0200);
        check("sb_raw1", {31'd0, stall}, 32'd1);
        next_cycle();
        check("sb_raw2", {31'd0, stall}, 32'd1);
        next_cycle();
        lu_done = 1'b1; lu_done_rd = 5'd9;
        #1 check("sb_raw_done_cycle", {31'd0, stall}, 32'd1);
        next_cycle();
        lu_done = 1'b0;
        #1 check("sb_cleared", busy, 32'd0);
        check("sb_release", {31'd0, stall}, 32'd0);
        check("sb_cnt", stall_cnt, 32'd4);
        id_use = '0;

        // Set wins over done; stray done and x0 issue ignored
        lu_issue = 1'b1; lu_rd = 5'd12;
        next_cycle();
        lu_done = 1'b1; lu_done_rd = 5'd12;
        #1 check("busy12", busy, 32'h0000_1000);
        next_cycle();
        lu_issue = 1'b0; lu_done_rd = 5'd3;
        #1 check("set_wins", busy, 32'h0000_1000);
        next_cycle();
        lu_done = 1'b0;
        check("done_nonbusy", busy, 32'h0000_1000);
        lu_issue = 1'b1; lu_rd = 5'd0;
        next_cycle();
        lu_issue = 1'b0;
        check("issue_x0", busy, 32'h0000_1000);

        // WAW
        lu_issue = 1'b1; lu_rd = 5'd4;
        next_cycle();
        lu_issue = 1'b0;
        check("busy4", busy, 32'h0000_1010);
        id_we = 1'b1; id_rd = 5'd4;
        #1 check("waw_stall", {31'd0, stall}, 32'd1);
        id_rd = 5'd5;
        #1 check("waw_free", {31'd0, stall}, 32'd0);
        next_cycle();
        id_we = 1'b0;
        check("cnt_after_waw", stall_cnt, 32'd4);

        // Reset mid-stall
        lu_issue = 1'b1; lu_rd = 5'd9;
        next_cycle();
        lu_issue = 1'b0; id_rs = {5'd0, 5'd9}; id_use = 2'b01;
        #1 check("pre_reset_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        check("pre_reset_cnt", stall_cnt, 32'd5);
        #1 rst_i = 1'b0;
        #1 check("async_busy", busy, 32'd0);
        check("async_cnt", stall_cnt, 32'd0);
        check("async_stall", {31'd0, stall}, 32'd0);
        #1 rst_i = 1'b1;
        next_cycle();
        lu_done = 1'b1; lu_done_rd = 5'd9;
        #1 check("post_reset_done", busy, 32'd0);
        next_cycle();
        lu_done = 1'b0;
        check("post_reset_busy", busy, 32'd0);
        check("post_reset_stall", {31'd0, stall}, 32'd0);
        check("post_reset_cnt", stall_cnt, 32'd0);
        id_use = '0;

        // Counter saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        #1 check("cnt_preload", stall_cnt, 32'hFFFF_FFFE);
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_use = 2'b01;
        next_cycle();
        check("cnt_max", stall_cnt, 32'hFFFF_FFFF);
        next_cycle();
        check("cnt_sat1", stall_cnt, 32'hFFFF_FFFF);
        next_cycle();
        check("cnt_sat2", stall_cnt, 32'hFFFF_FFFF);
        ex_memread = 1'b0; id_use = '0;

        // Three-operand, three-stage build
        fwd_we3 = 3'b110; fwd_rd3 = {5'd10, 5'd11, 5'd10}; ex_rs3 = {5'd10, 5'd11, 5'd3};
        #1 check("n3_sel_stage2", {26'd0, fwd_sel3}, 32'b111000);
        fwd_we3 = 3'b111;
        #1 check("n3_sel_nearest", {26'd0, fwd_sel3}, 32'b011000);
        check("n3_stall", {31'd0, stall3}, 32'd0);
        check("n3_busy", busy3, 32'd0);
        check("n3_cnt", stall_cnt3, 32'd0);

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
